irq_trap_ctrl: RTL and testbench

IRQ_TRAP_CTRL -- requirements
Module: irq_trap_ctrl

---
 rtl/irq_trap_ctrl.sv | 138 +++++++++++++
 tb/tb_irq_trap_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt trap sequencer: picks the highest-priority pending
// interrupt, drains the pipeline, requests the trap, then holds off briefly.
module irq_trap_ctrl #(
  parameter int unsigned DRAIN_MAX = 16,
  parameter int unsigned HOLDOFF   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mip,
  input  logic [31:0] mie,
  input  logic [31:0] mstatus,
  input  logic [1:0]  priv,
  input  logic        pipe_empty,
  input  logic        irq_ack,
  output logic        stall_fetch,
  output logic        irq_req,
  output logic [31:0] irq_cause,
  output logic        drain_timeout
);

  localparam int unsigned CAUSE_W  = 32;
  localparam int unsigned CODE_W   = 5;
  localparam int unsigned CNT_MAX  = (DRAIN_MAX > HOLDOFF) ? DRAIN_MAX : HOLDOFF;
  localparam int unsigned CNT_W    = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [31:0] SRC_MASK = 32'h0000_0AAA;
  localparam logic [1:0]  PRIV_M   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_REQ,
    S_HOLD
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CAUSE_W-1:0]   cause_q, cause_d;
  logic                 stall_q, stall_d;
  logic                 req_q, req_d;
  logic                 timeout_q, timeout_d;

  logic [31:0]          irq_en;
  logic                 gie;
  logic                 pend;
  logic [CODE_W-1:0]    sel_code;
  logic [CAUSE_W-1:0]   sel_cause;
  logic                 unused_ok;

  assign unused_ok = &{1'b0, mip[31:12], mie[31:12], mstatus[31:4], mstatus[2:0]};

  assign irq_en    = mip & mie & SRC_MASK;
  assign gie       = (priv != PRIV_M) | mstatus[3];
  assign pend      = (|irq_en) & gie;
  assign sel_cause = {1'b1, 26'b0, sel_code};

  // Fixed priority: MEI, MSI, MTI, SEI, SSI, STI
  always_comb begin
    sel_code = CODE_W'(0);
    if      (irq_en[11]) sel_code = CODE_W'(11);
    else if (irq_en[3])  sel_code = CODE_W'(3);
    else if (irq_en[7])  sel_code = CODE_W'(7);
    else if (irq_en[9])  sel_code = CODE_W'(9);
    else if (irq_en[1])  sel_code = CODE_W'(1);
    else if (irq_en[5])  sel_code = CODE_W'(5);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cause_q   <= '0;
      stall_q   <= 1'b0;
      req_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cause_q   <= cause_d;
      stall_q   <= stall_d;
      req_q     <= req_d;
      timeout_q <= timeout_d;
    end
  end

  // Next state; the single counter serves as drain timer and holdoff timer
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cause_d   = cause_q;
    timeout_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pend) begin
          state_d = S_DRAIN;
          cause_d = sel_cause;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!pend) begin
          state_d = S_IDLE;
        end else begin
          cause_d = sel_cause;
          if (pipe_empty) begin
            state_d = S_REQ;
          end else if (cnt_q == CNT_W'(DRAIN_MAX - 1)) begin
            timeout_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_REQ: begin
        if (irq_ack) begin
          state_d = S_HOLD;
          cnt_d   = CNT_W'(HOLDOFF - 1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stall tracks the state register; the request lags entry into REQ by a cycle
  always_comb begin
    stall_d = (state_d == S_DRAIN) || (state_d == S_REQ);
    req_d   = (state_q == S_REQ) && !irq_ack;
  end

  assign stall_fetch   = stall_q;
  assign irq_req       = req_q;
  assign irq_cause     = cause_q;
  assign drain_timeout = timeout_q;

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Scoreboard bench for irq_trap_ctrl: per-cycle expected outputs are queued
// by the driver and compared by a monitor just after each rising edge.
module tb_irq_trap_ctrl;

  localparam logic [1:0]  PM  = 2'd3;
  localparam logic [1:0]  PU  = 2'd0;
  localparam logic [31:0] MST = 32'h0000_0008;
  localparam logic [31:0] C3  = 32'h8000_0003;
  localparam logic [31:0] C7  = 32'h8000_0007;
  localparam logic [31:0] C9  = 32'h8000_0009;
  localparam logic [31:0] CB  = 32'h8000_000B;

  typedef struct packed {
    logic        stall;
    logic        req;
    logic [31:0] cause;
    logic        to;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mip, mie, mstatus;
  logic [1:0]  priv;
  logic        pipe_empty, irq_ack;
  logic        stall_fetch, irq_req, drain_timeout;
  logic [31:0] irq_cause;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   step_n = 0;

  irq_trap_ctrl #(.DRAIN_MAX(16), .HOLDOFF(2)) dut (
    .clk(clk), .rst(rst), .mip(mip), .mie(mie), .mstatus(mstatus),
    .priv(priv), .pipe_empty(pipe_empty), .irq_ack(irq_ack),
    .stall_fetch(stall_fetch), .irq_req(irq_req),
    .irq_cause(irq_cause), .drain_timeout(drain_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", tag, step_n, got, exp);
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge
  task automatic cyc(input logic r, input logic [31:0] ip, input logic [31:0] ie,
                     input logic [31:0] ms, input logic [1:0] pv, input logic pe,
                     input logic ak, input logic e_st, input logic e_rq,
                     input logic [31:0] e_ca, input logic e_to);
    exp_t e;
    @(negedge clk);
    rst = r; mip = ip; mie = ie; mstatus = ms; priv = pv;
    pipe_empty = pe; irq_ack = ak;
    e.stall = e_st; e.req = e_rq; e.cause = e_ca; e.to = e_to;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      step_n++;
      chk("stall_fetch", 32'(stall_fetch), 32'(e.stall));
      chk("irq_req", 32'(irq_req), 32'(e.req));
      chk("irq_cause", irq_cause, e.cause);
      chk("drain_timeout", 32'(drain_timeout), 32'(e.to));
    end
  end

  initial begin
    rst = 1'b1; mip = '0; mie = '0; mstatus = '0; priv = PM;
    pipe_empty = 1'b0; irq_ack = 1'b0;

    // Reset state
    cyc(1, 0, 0, 0, PM, 0, 0, 0, 0, 0, 0);

    // MTI: one drain cycle, request, ack, two holdoff cycles, pending re-served
    cyc(0, 32'h80, 32'h80, MST, PM, 1, 0, 1, 0, C7, 0);
    cyc(0, 32'h80, 32'h80, MST, PM, 1, 0, 1, 0, C7, 0);
    cyc(0, 32'h80, 32'h80, MST, PM, 1, 0, 1, 1, C7, 0);
    cyc(0, 32'h80, 32'h80, MST, PM, 1, 1, 0, 0, C7, 0);
    cyc(0, 32'h80, 32'h80, MST, PM, 1, 0, 0, 0, C7, 0);
    cyc(0, 32'h80, 32'h80, MST, PM, 1, 0, 0, 0, C7, 0);
    cyc(0, 32'h80, 32'h80, MST, PM, 1, 0, 1, 0, C7, 0);
    cyc(0, 32'h80, 32'h80, MST, PM, 1, 0, 1, 0, C7, 0);
    // mip clears while requesting: request held until ack
    cyc(0, 32'h0, 32'h80, MST, PM, 1, 0, 1, 1, C7, 0);
    cyc(0, 32'h0, 32'h80, MST, PM, 1, 0, 1, 1, C7, 0);
    cyc(0, 32'h0, 32'h80, MST, PM, 1, 1, 0, 0, C7, 0);
    cyc(0, 32'h0, 32'h80, MST, PM, 1, 0, 0, 0, C7, 0);
    cyc(0, 32'h0, 32'h80, MST, PM, 1, 0, 0, 0, C7, 0);
    cyc(0, 32'h0, 32'h80, MST, PM, 1, 0, 0, 0, C7, 0);

    // Higher-priority MEI arrives during drain and replaces MTI
    cyc(1, 0, 0, 0, PM, 0, 0, 0, 0, 0, 0);
    cyc(0, 32'h80,  32'h880, MST, PM, 0, 0, 1, 0, C7, 0);
    cyc(0, 32'h880, 32'h880, MST, PM, 0, 0, 1, 0, CB, 0);
    cyc(0, 32'h880, 32'h880, MST, PM, 1, 0, 1, 0, CB, 0);
    cyc(0, 32'h880, 32'h880, MST, PM, 1, 0, 1, 1, CB, 0);
    cyc(0, 32'h0,   32'h880, MST, PM, 1, 1, 0, 0, CB, 0);
    cyc(0, 32'h0,   32'h880, MST, PM, 1, 0, 0, 0, CB, 0);
    cyc(0, 32'h0,   32'h880, MST, PM, 1, 0, 0, 0, CB, 0);

    // Drain timeout after 16 cycles without pipe_empty
    cyc(1, 0, 0, 0, PM, 0, 0, 0, 0, 0, 0);
    cyc(0, 32'h80, 32'h80, MST, PM, 0, 0, 1, 0, C7, 0);
    for (int i = 0; i < 15; i++)
      cyc(0, 32'h80, 32'h80, MST, PM, 0, 0, 1, 0, C7, 0);
    cyc(0, 32'h80, 32'h80, MST, PM, 0, 0, 0, 0, C7, 1);
    cyc(0, 32'h0,  32'h80, MST, PM, 0, 0, 0, 0, C7, 0);
    cyc(0, 32'h0,  32'h80, MST, PM, 0, 0, 0, 0, C7, 0);

    // M-mode with MIE clear masks; dropping to U-mode takes the MSI
    cyc(1, 0, 0, 0, PM, 0, 0, 0, 0, 0, 0);
    cyc(0, 32'h8, 32'h8, 32'h0, PM, 1, 0, 0, 0, 0, 0);
    cyc(0, 32'h8, 32'h8, 32'h0, PM, 1, 0, 0, 0, 0, 0);
    cyc(0, 32'h8, 32'h8, 32'h0, PU, 1, 0, 1, 0, C3, 0);
    cyc(0, 32'h8, 32'h8, 32'h0, PU, 1, 0, 1, 0, C3, 0);
    cyc(0, 32'h8, 32'h8, 32'h0, PU, 1, 0, 1, 1, C3, 0);

    // Reset while requesting, then a spurious ack does nothing
    cyc(1, 32'h8, 32'h8, 32'h0, PU, 1, 0, 0, 0, 0, 0);
    cyc(0, 32'h0, 32'h8, 32'h0, PU, 1, 1, 0, 0, 0, 0);
    cyc(0, 32'h0, 32'h8, 32'h0, PU, 1, 1, 0, 0, 0, 0);
    cyc(0, 32'h0, 32'h8, 32'h0, PU, 1, 0, 0, 0, 0, 0);

    // Source withdrawn during drain: back to idle, no request, no timeout
    cyc(0, 32'h80, 32'h80, MST, PM, 0, 0, 1, 0, C7, 0);
    cyc(0, 32'h0,  32'h80, MST, PM, 0, 0, 0, 0, C7, 0);
    cyc(0, 32'h0,  32'h80, MST, PM, 0, 0, 0, 0, C7, 0);

    // SEI beats SSI and STI
    cyc(0, 32'h222, 32'hFFFF_FFFF, MST, PM, 0, 0, 1, 0, C9, 0);
    cyc(0, 32'h0,   32'hFFFF_FFFF, MST, PM, 0, 0, 0, 0, C9, 0);

    // Non-source bits are ignored
    cyc(0, 32'hFFFF_F555, 32'hFFFF_FFFF, MST, PM, 1, 0, 0, 0, C9, 0);
    cyc(0, 32'hFFFF_F555, 32'hFFFF_FFFF, MST, PM, 1, 0, 0, 0, C9, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
